rb_regbank: RTL



---
 rtl/Minivan_pkg.sv | 37 +++
 rtl/rb_regbank_sticky.sv | 31 +++
 rtl/rb_regbank.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/Minivan_pkg.sv
// Minivan_pkg: shared types and constants for the Minivan register bank.
// Holds the bus FSM state type, default bank geometry and the mapping of
// the legacy sys_cfg fields onto configuration words of cfg_o.
package Minivan_pkg;

  // Default bank geometry
  localparam int RB_AW    = 5;
  localparam int RB_DW    = 8;
  localparam int RB_NCFG  = 8;
  localparam int RB_NSTAT = 4;

  // Bus access FSM
  typedef enum logic [1:0] {
    RB_IDLE = 2'd0,
    RB_RESP = 2'd1,
    RB_HOLD = 2'd2
  } rb_fsm_t;

  // Word index of each former sys_cfg field inside cfg_o
  localparam int SYS_CFG_ENABLE_WORD  = 0;
  localparam int SYS_CFG_MONITOR_WORD = 1;
  localparam int SYS_CFG_PWM0_WORD    = 2;
  localparam int SYS_CFG_PWM1_WORD    = 3;
  localparam int SYS_CFG_PWM2_WORD    = 4;
  localparam int SYS_CFG_PWM3_WORD    = 5;
  localparam int SYS_CFG_SPARE0_WORD  = 6;
  localparam int SYS_CFG_SPARE1_WORD  = 7;

  // Bit offsets of those fields in the flat cfg_o vector (default DW)
  localparam int SYS_CFG_ENABLE_LSB  = SYS_CFG_ENABLE_WORD  * RB_DW;
  localparam int SYS_CFG_MONITOR_LSB = SYS_CFG_MONITOR_WORD * RB_DW;
  localparam int SYS_CFG_PWM0_LSB    = SYS_CFG_PWM0_WORD    * RB_DW;
  localparam int SYS_CFG_PWM1_LSB    = SYS_CFG_PWM1_WORD    * RB_DW;
  localparam int SYS_CFG_PWM2_LSB    = SYS_CFG_PWM2_WORD    * RB_DW;
  localparam int SYS_CFG_PWM3_LSB    = SYS_CFG_PWM3_WORD    * RB_DW;

endpackage

// File: rtl/rb_regbank_sticky.sv
// rb_sticky_w1c: one sticky status word. Bits set from event inputs stay
// set until cleared by a write-1-to-clear; a set in the same cycle wins.
module rb_sticky_w1c
  import Minivan_pkg::*;
#(
  parameter int DW = RB_DW
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic [DW-1:0] set_i,
  input  logic [DW-1:0] clr_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] q_q;
  logic [DW-1:0] q_d;

  // Clear first, then OR in new events so a simultaneous set survives
  always_comb begin
    q_d = (q_q & ~clr_i) | set_i;
  end

  // Status word storage
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/rb_regbank.sv
// rb_regbank: NCFG read/write configuration words plus NSTAT sticky W1C
// status words behind a req/ack bus. Optional feature macro RB_SHADOW_EN:
// config writes land in a shadow copy and reach cfg_o only on commit_i.
module rb_regbank
  import Minivan_pkg::*;
#(
  parameter int AW    = RB_AW,
  parameter int DW    = RB_DW,
  parameter int NCFG  = RB_NCFG,
  parameter int NSTAT = RB_NSTAT,
  parameter logic [NCFG*DW-1:0] CFG_RST = '0
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [DW-1:0]       wdata_i,
  output logic                ack_o,
  output logic [DW-1:0]       rdata_o,
  output logic                err_o,
  output logic [NCFG*DW-1:0]  cfg_o,
  output logic                update_o,
  input  logic [NSTAT*DW-1:0] stat_i,
  input  logic                commit_i
);

  localparam int NREG = NCFG + NSTAT;

  rb_fsm_t              state_q, state_d;
  logic                 we_q;
  logic [AW-1:0]        addr_q;
  logic [DW-1:0]        wdata_q;

  logic                 inRange;
  logic                 cfgHit;
  logic                 statHit;
  logic                 wrCfg;
  logic                 wrStat;

  logic [NCFG*DW-1:0]   store_q, store_d;
  logic [NSTAT*DW-1:0]  statClr;
  logic [NSTAT*DW-1:0]  statWords;
  logic [DW-1:0]        rdataMux;
  logic                 update_q;

  // Address decode of the latched access
  always_comb begin
    inRange = (int'(addr_q) < NREG);
    cfgHit  = (int'(addr_q) < NCFG);
    statHit = inRange && !cfgHit;
    wrCfg   = (state_q == RB_RESP) && we_q && cfgHit;
    wrStat  = (state_q == RB_RESP) && we_q && statHit;
  end

  // Next-state logic: accept in IDLE, respond once, hold until req drops
  always_comb begin
    state_d = state_q;
    case (state_q)
      RB_IDLE: if (req_i) state_d = RB_RESP;
      RB_RESP: state_d = req_i ? RB_HOLD : RB_IDLE;
      RB_HOLD: if (!req_i) state_d = RB_IDLE;
      default: state_d = RB_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state_q <= RB_IDLE;
    else         state_q <= state_d;
  end

  // Capture the access in IDLE so an early req drop still completes it
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if ((state_q == RB_IDLE) && req_i) begin
      we_q    <= we_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end
  end

  // Config write target: the live words, or the shadow when enabled
  always_comb begin
    store_d = store_q;
    if (wrCfg) begin
      for (int k = 0; k < NCFG; k++) begin
        if (addr_q == AW'(k)) store_d[k*DW +: DW] = wdata_q;
      end
    end
  end

  // Config (or shadow) word storage
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) store_q <= CFG_RST;
    else         store_q <= store_d;
  end

`ifdef RB_SHADOW_EN
  logic [NCFG*DW-1:0] live_q;

  // Commit copies the whole shadow at once; a same-edge write is not included
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      live_q   <= CFG_RST;
      update_q <= 1'b0;
    end else begin
      if (commit_i) live_q <= store_q;
      update_q <= commit_i;
    end
  end

  assign cfg_o = live_q;
`else
  logic unusedCommit;
  assign unusedCommit = commit_i;

  // Direct mode: the store is live, so flag each config write load
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) update_q <= 1'b0;
    else         update_q <= wrCfg;
  end

  assign cfg_o = store_q;
`endif

  // W1C clear mask for the addressed status word during a write response
  always_comb begin
    statClr = '0;
    if (wrStat) begin
      for (int j = 0; j < NSTAT; j++) begin
        if (addr_q == AW'(NCFG + j)) statClr[j*DW +: DW] = wdata_q;
      end
    end
  end

  for (genvar g = 0; g < NSTAT; g++) begin : gStat
    rb_sticky_w1c #(.DW(DW)) uSticky (
      .clk    (clk),
      .resetb (resetb),
      .set_i  (stat_i[g*DW +: DW]),
      .clr_i  (statClr[g*DW +: DW]),
      .q_o    (statWords[g*DW +: DW])
    );
  end

  // Read data: zero outside the response or for an out-of-range address
  always_comb begin
    rdataMux = '0;
    if ((state_q == RB_RESP) && inRange) begin
      for (int k = 0; k < NCFG; k++) begin
        if (addr_q == AW'(k)) rdataMux = store_q[k*DW +: DW];
      end
      for (int j = 0; j < NSTAT; j++) begin
        if (addr_q == AW'(NCFG + j)) rdataMux = statWords[j*DW +: DW];
      end
    end
  end

  assign ack_o    = (state_q == RB_RESP);
  assign err_o    = (state_q == RB_RESP) && !inRange;
  assign rdata_o  = rdataMux;
  assign update_o = update_q;

endmodule
